// File: rtl/prirv32_alu_hs.sv
// prirv32_alu_hs: valid/ready execute ALU with a registered result/condition output.
// PRIRV32_BARREL_SHIFT_EN selects single-cycle barrel shifts; otherwise shifts iterate one bit per cycle.
module prirv32_alu_hs #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic             cmp_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_NE   = 4'd11;
  localparam logic [3:0] OP_GE   = 4'd12;
  localparam logic [3:0] OP_GEU  = 4'd13;

  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  alu_res;
  logic             alu_cmp;
  logic             is_cmp;
  logic             out_free;
  logic             accept;

  logic             wr_en;
  logic [XLEN-1:0]  wr_res;
  logic             wr_cmp;
  logic [TAG_W-1:0] wr_tag;

  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic             cmp_q;
  logic [TAG_W-1:0] tag_q;

  assign shamt    = op_b_i[SHW-1:0];
  assign out_free = !out_valid_q || out_ready_i;
  assign accept   = in_valid_i && in_ready_o;

  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    is_cmp  = 1'b0;
    case (op_i)
      OP_ADD:  alu_res = op_a_i + op_b_i;
      OP_SUB:  alu_res = op_a_i - op_b_i;
      OP_XOR:  alu_res = op_a_i ^ op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_SLT:  begin is_cmp = 1'b1; alu_cmp = $signed(op_a_i) < $signed(op_b_i);   end
      OP_SLTU: begin is_cmp = 1'b1; alu_cmp = op_a_i < op_b_i;                     end
      OP_EQ:   begin is_cmp = 1'b1; alu_cmp = op_a_i == op_b_i;                    end
      OP_NE:   begin is_cmp = 1'b1; alu_cmp = op_a_i != op_b_i;                    end
      OP_GE:   begin is_cmp = 1'b1; alu_cmp = $signed(op_a_i) >= $signed(op_b_i);  end
      OP_GEU:  begin is_cmp = 1'b1; alu_cmp = op_a_i >= op_b_i;                    end
`ifdef PRIRV32_BARREL_SHIFT_EN
      OP_SLL:  alu_res = op_a_i << shamt;
      OP_SRL:  alu_res = op_a_i >> shamt;
      OP_SRA:  alu_res = $signed(op_a_i) >>> shamt;
`else
      // Only reaches the output directly for a zero shift amount.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a_i;
`endif
      default: ;
    endcase
    if (is_cmp) alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
  end

`ifdef PRIRV32_BARREL_SHIFT_EN
  assign in_ready_o = out_free;

  always_comb begin
    wr_en  = accept;
    wr_res = alu_res;
    wr_cmp = alu_cmp;
    wr_tag = tag_i;
  end
`else
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [1:0] SH_SLL  = 2'd0;
  localparam logic [1:0] SH_SRL  = 2'd1;
  localparam logic [1:0] SH_SRA  = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  work_q, work_d, work_step, work_nxt;
  logic [SHW-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [1:0]       shop_q, shop_d;
  logic [TAG_W-1:0] shtag_q, shtag_d;
  logic             is_shift;

  assign is_shift   = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);
  assign in_ready_o = (state_q == S_IDLE) && out_free;

  always_comb begin
    case (shop_q)
      SH_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
      SH_SRA:  work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_step = {work_q[XLEN-2:0], 1'b0};
    endcase
    // A zero count means the shift finished but is waiting for the output slot.
    work_nxt = (cnt_q != '0) ? work_step : work_q;
    cnt_nxt  = (cnt_q != '0) ? cnt_q - SHW'(1) : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    shop_d  = shop_q;
    shtag_d = shtag_q;
    wr_en   = 1'b0;
    wr_res  = alu_res;
    wr_cmp  = alu_cmp;
    wr_tag  = tag_i;
    if (state_q == S_IDLE) begin
      if (accept) begin
        if (is_shift && (shamt != '0)) begin
          state_d = S_SHIFT;
          work_d  = op_a_i;
          cnt_d   = shamt;
          shop_d  = (op_i == OP_SRL) ? SH_SRL : (op_i == OP_SRA) ? SH_SRA : SH_SLL;
          shtag_d = tag_i;
        end else begin
          wr_en = 1'b1;
        end
      end
    end else begin
      work_d = work_nxt;
      cnt_d  = cnt_nxt;
      if ((cnt_nxt == '0) && out_free) begin
        wr_en   = 1'b1;
        wr_res  = work_nxt;
        wr_cmp  = 1'b0;
        wr_tag  = shtag_q;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      shop_q  <= SH_SLL;
      shtag_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      shop_q  <= shop_d;
      shtag_q <= shtag_d;
    end
  end
`endif

  // A new write wins over consumption of the previous result on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      tag_q       <= '0;
    end else if (wr_en) begin
      out_valid_q <= 1'b1;
      result_q    <= wr_res;
      cmp_q       <= wr_cmp;
      tag_q       <= wr_tag;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign cmp_o       = cmp_q;
  assign tag_o       = tag_q;
endmodule

// File: doc/prirv32_alu_hs.md
# prirv32_alu_hs

Parametrised, handshaked successor to the combinational priRV32 execute ALU. It accepts pre-selected operands and a compact ALU opcode over a valid/ready input channel and computes the arithmetic, logic, compare or shift result. The result and branch-condition bit are delivered through a registered valid/ready output channel. It sits between the decode/operand-select stage and writeback/branch resolution, so the pipeline can stall on back-pressure and shifts can run iteratively.

## Interface
- XLEN, 32: datapath width; legal values 8..64, power of two.
- TAG_W, 5: width of the opaque tag carried alongside each operation (rd index).
- SHW: not overridable; log2(XLEN), the shift-amount width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  block can accept an operation this cycle.
- op_i  in  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 GE, 13 GEU; 14/15 reserved.
- op_a_i  in  XLEN  operand A (rs1 or PC, already selected upstream).
- op_b_i  in  XLEN  operand B (rs2 or immediate); shifts use op_b_i[SHW-1:0] only.
- tag_i  in  TAG_W  tag captured with the operation.
- out_valid_o  out  1  result register holds a valid result.
- out_ready_i  in  1  consumer takes the result this cycle.
- result_o  out  XLEN  result; compare ops give zero-extended 0/1.
- cmp_o  out  1  condition bit; equals result_o[0] for opcodes 3,4,10..13, else 0.
- tag_o  out  TAG_W  tag of the operation in result_o.

## Operation
- Transfer occurs on an edge where valid and ready are both high, on either channel.
- States:
  - IDLE: waiting for an operation.
  - SHIFT: iterative shift in progress (only when the macro is absent).
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). It is combinational and does not depend on in_valid_i.
- Single-cycle ops (all except shifts with nonzero amount in iterative mode):
  - On accept, result_o, cmp_o and tag_o are written and out_valid_o is set.
  - Throughput is 1 op per cycle while out_ready_i is held high.
- SLT/GE are signed; SLTU/GEU are unsigned. ADD/SUB wrap modulo 2^XLEN.
- SRA replicates op_a_i[XLEN-1]. SRL and SLL fill with zeros.
- Reserved opcodes: result_o=0, cmp_o=0, latency 1, no error flag.
- out_valid_o clears on an edge with out_ready_i=1 unless a new result is written on the same edge; a write takes priority.
- Output registers hold stable while out_valid_o && !out_ready_i.

## Timing
- Reset values: out_valid_o=0, result_o=0, cmp_o=0, tag_o=0, state=IDLE. in_ready_o therefore reads 1 after reset.
- Reset asserted mid-shift aborts the operation; no result is produced.
- Single-cycle op latency: accept at edge N, out_valid_o=1 after edge N.
- Iterative shift, shift amount s:
  - s=0: behaves as a single-cycle op.
  - s>0: at the accept edge, load working register and count=s, then enter SHIFT.
  - Each SHIFT edge shifts by 1 and decrements count.
  - On the edge where count reaches 0, write the output and return to IDLE.
  - Latency is s cycles; in_ready_o=0 throughout SHIFT.
- If the output register is still occupied when count reaches 0, the block holds in SHIFT with count=0. It writes on the first edge where !out_valid_o || out_ready_i.
- in_valid_i while in_ready_o=0 is ignored; upstream must hold its inputs stable until accepted.

## Configuration
- PRIRV32_BARREL_SHIFT_EN defined:
  - Shifts use a single-cycle barrel shifter with latency 1 for every opcode.
  - The SHIFT state and counter are not built.
- PRIRV32_BARREL_SHIFT_EN undefined:
  - Shifts run iteratively, 1 bit per cycle, as above.
  - Smaller area, variable latency.

## Test plan
- Reset then ADD 0xFFFFFFFF+1, tag 7, out_ready_i=1: result_o=0 and tag_o=7 one cycle after accept; in_ready_o=1 throughout.
- Back-to-back SUB 5-7, SLT 0xFFFFFFFE<1, SLTU same operands, consumer always ready: results 0xFFFFFFFE, 1 (cmp_o=1), 0 (cmp_o=0) on consecutive cycles.
- BGE/EQ checks: GE -1,-1 gives cmp_o=1; GEU 0x80000000,1 gives cmp_o=1; NE 3,3 gives cmp_o=0.
- Iterative build, SRA 0x80000000 by 31: out_valid_o rises 31 cycles after accept with result 0xFFFFFFFF; in_ready_o=0 during the shift. Barrel build gives the same result after 1 cycle.
- Back-pressure: out_ready_i=0 with an XOR result held. in_ready_o=0 and a second op is not accepted; result_o stays stable. Raising out_ready_i accepts the second op on the same edge the first is consumed.
- Assert rst_i mid-way through an SLL by 20: out_valid_o=0 immediately, state returns to IDLE, and the next ADD completes normally with latency 1.
